tdm_demux: RTL and testbench

- Receive end of the team's time-division multiplexed link. Each slot on the shared input carries one sample from one channel; the mux end selects and sends the slots.
- This block locks onto the frame marker and routes each slot to its own registered channel output.
- It flags framing errors and drops lock when the marker is missing.
- It sits between the serial link and the per-channel consumers.

---
 rtl/tdm_demux.sv | 89 ++++++++
 tb/tb_tdm_demux.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a TDM link; locks to the frame marker and routes each slot to a registered channel output
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   din        - slot sample
//   din_valid  - din and frame_sync are valid this cycle
//   frame_sync - marks the slot 0 sample (qualified by din_valid)
//   ch_data    - channel k held in [k*WIDTH +: WIDTH]
//   ch_valid   - one-cycle pulse on bit k when channel k is written
//   frame_done - one-cycle pulse when the last slot of a frame is written
//   locked     - high while locked to the frame
//   sync_err   - one-cycle pulse on a framing violation
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [CHANNELS-1:0]       ch_valid,
    output logic                      frame_done,
    output logic                      locked,
    output logic                      sync_err
);
    localparam int CW = $clog2(CHANNELS);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [CHANNELS*WIDTH-1:0] ch_data_q, ch_data_d;
    logic [CHANNELS-1:0]       ch_valid_q, ch_valid_d;
    logic                      frame_done_q, frame_done_d;
    logic                      sync_err_q, sync_err_d;
    logic                      last;
    assign last = cnt_q == CW'(CHANNELS - 1);
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        if (din_valid) begin
            if (frame_sync) begin
                // A marker always restarts the frame at slot 0; it is only an error if it arrives early while locked
                sync_err_d            = state_q == LOCKED && cnt_q != '0;
                ch_data_d[0+:WIDTH]   = din;
                ch_valid_d            = CHANNELS'(1);
                cnt_d                 = CW'(1);
                state_d               = LOCKED;
            end else if (state_q == LOCKED) begin
                if (cnt_q == '0) begin
                    // Slot 0 without a marker: lock is lost and the sample discarded
                    sync_err_d = 1'b1;
                    state_d    = HUNT;
                end else begin
                    ch_data_d[cnt_q*WIDTH+:WIDTH] = din;
                    ch_valid_d                    = CHANNELS'(1) << cnt_q;
                    frame_done_d                  = last;
                    cnt_d                         = last ? '0 : cnt_q + CW'(1);
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            cnt_q        <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end
    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = state_q == LOCKED;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed self-checking bench for tdm_demux with CHANNELS=4, WIDTH=8
module tb_tdm_demux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic        frame_done;
    logic        locked;
    logic        sync_err;
    int total = 0;
    int bad = 0;

    tdm_demux #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Apply one cycle of input, then settle just after the sampling edge
    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'hEE);
        drive(1'b0, 1'b0, 8'h00);
        total++;
        if ({ch_data, ch_valid, frame_done, locked, sync_err} !== 40'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {ch_data, ch_valid, frame_done, locked, sync_err});
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h11);
        drive(1'b1, 1'b0, 8'h22);
        total++;
        if ({ch_data, ch_valid, frame_done, locked, sync_err} !== 40'h0) begin
            bad++;
            $display("FAIL hunt_discard got=%h exp=0", {ch_data, ch_valid, frame_done, locked, sync_err});
        end
    endtask

    task automatic test_clean();
        logic [7:0] vals [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i % 4 == 0, vals[i]);
            total++;
            if (ch_valid !== 4'(1 << (i % 4)) || frame_done !== (i % 4 == 3) || sync_err !== 1'b0 || locked !== 1'b1) begin
                bad++;
                $display("FAIL clean_slot%0d got v=%h fd=%b err=%b lk=%b exp v=%h fd=%b err=0 lk=1",
                         i, ch_valid, frame_done, sync_err, locked, 4'(1 << (i % 4)), i % 4 == 3);
            end
        end
        total++;
        if (ch_data !== 32'hB3B2B1B0) begin
            bad++;
            $display("FAIL clean_data got=%h exp=B3B2B1B0", ch_data);
        end
    endtask

    task automatic test_idle_gaps();
        logic [7:0] vals [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        logic [31:0] hold;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, vals[i]);
            total++;
            if (ch_valid !== 4'(1 << i) || frame_done !== (i == 3) || sync_err !== 1'b0) begin
                bad++;
                $display("FAIL gap_slot%0d got v=%h fd=%b err=%b exp v=%h fd=%b err=0",
                         i, ch_valid, frame_done, sync_err, 4'(1 << i), i == 3);
            end
            hold = ch_data;
            // Gap cycles carry a spurious marker that must be ignored
            for (int g = 0; g < 3; g++) begin
                drive(1'b0, 1'b1, 8'hFF);
                total++;
                if (ch_valid !== 4'h0 || frame_done !== 1'b0 || sync_err !== 1'b0 || ch_data !== hold || locked !== 1'b1) begin
                    bad++;
                    $display("FAIL gap_idle%0d_%0d got v=%h fd=%b err=%b d=%h lk=%b exp v=0 fd=0 err=0 d=%h lk=1",
                             i, g, ch_valid, frame_done, sync_err, ch_data, locked, hold);
                end
            end
        end
        total++;
        if (ch_data !== 32'hC3C2C1C0) begin
            bad++;
            $display("FAIL gap_data got=%h exp=C3C2C1C0", ch_data);
        end
    endtask

    task automatic test_early_marker();
        logic [7:0] vals [6] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23};
        logic       syn  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] ev   [6] = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, syn[i], vals[i]);
            total++;
            if (ch_valid !== ev[i] || sync_err !== (i == 2) || frame_done !== (i == 5) || locked !== 1'b1) begin
                bad++;
                $display("FAIL early_step%0d got v=%h err=%b fd=%b lk=%b exp v=%h err=%b fd=%b lk=1",
                         i, ch_valid, sync_err, frame_done, locked, ev[i], i == 2, i == 5);
            end
        end
        total++;
        if (ch_data !== 32'h23222120) begin
            bad++;
            $display("FAIL early_data got=%h exp=23222120", ch_data);
        end
    endtask

    task automatic test_missing_marker();
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 8'hD0 + 8'(i));
        drive(1'b1, 1'b0, 8'h55);
        total++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || ch_valid !== 4'h0 || frame_done !== 1'b0 || ch_data !== 32'hD3D2D1D0) begin
            bad++;
            $display("FAIL missing_err got err=%b lk=%b v=%h fd=%b d=%h exp err=1 lk=0 v=0 fd=0 d=D3D2D1D0",
                     sync_err, locked, ch_valid, frame_done, ch_data);
        end
        drive(1'b1, 1'b0, 8'h66);
        total++;
        if (sync_err !== 1'b0 || locked !== 1'b0 || ch_valid !== 4'h0 || ch_data !== 32'hD3D2D1D0) begin
            bad++;
            $display("FAIL missing_hunt got err=%b lk=%b v=%h d=%h exp err=0 lk=0 v=0 d=D3D2D1D0",
                     sync_err, locked, ch_valid, ch_data);
        end
        drive(1'b1, 1'b1, 8'h77);
        total++;
        if (sync_err !== 1'b0 || locked !== 1'b1 || ch_valid !== 4'h1 || ch_data !== 32'hD3D2D177) begin
            bad++;
            $display("FAIL missing_relock got err=%b lk=%b v=%h d=%h exp err=0 lk=1 v=1 d=D3D2D177",
                     sync_err, locked, ch_valid, ch_data);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b0, 8'h02);
        total++;
        if (ch_valid !== 4'h2 || ch_data[15:0] !== 16'h0201) begin
            bad++;
            $display("FAIL midrst_pre got v=%h d=%h exp v=2 d[15:0]=0201", ch_valid, ch_data);
        end
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'h03);
        rst_n = 1'b1;
        total++;
        if ({ch_data, ch_valid, frame_done, locked, sync_err} !== 40'h0) begin
            bad++;
            $display("FAIL midrst_reset got=%h exp=0", {ch_data, ch_valid, frame_done, locked, sync_err});
        end
        drive(1'b1, 1'b0, 8'h03);
        total++;
        if ({ch_data, ch_valid, frame_done, locked, sync_err} !== 40'h0) begin
            bad++;
            $display("FAIL midrst_hunt got=%h exp=0", {ch_data, ch_valid, frame_done, locked, sync_err});
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_idle_gaps();
        test_early_marker();
        test_missing_marker();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
